regfile_bist: RTL and testbench
===============================

# regfile_bist

Built-in self-test sequencer for the 8 x 16-bit register file. It drives the register file's write port (`data_in`, `writenum`, `write`) and read port (`readnum`) and checks `data_out`, the initiator side of the same interface the register file responds to. It sits beside the register file behind a mux controlled by `busy`, and runs a fixed pattern sweep on `start`. It reports pass/fail, an error count and the first failing location.

## Interface

Parameters:

- `NUM_STEP`, default 8: number of arithmetic-sequence patterns after the two fixed patterns.
- `SEED`, default 16'h000F: first arithmetic pattern.
- `STEP`, default 16'h0C59: increment between arithmetic patterns, modulo 2^16.

Ports (one clock; reset is asynchronous and active-high):

- `clk`  in  1  rising-edge clock, shared with the register file.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE or DONE only.
- `abort`  in  1  cancel a run in progress.
- `data_out`  in  16  combinational read data from the register file.
- `data_in`  out  16  write data to the register file.
- `writenum`  out  3  write address.
- `write`  out  1  write enable.
- `readnum`  out  3  read address.
- `busy`  out  1  high while in the WRITE or READ state.
- `done`  out  1  run complete; held until the next `start` or `reset`.
- `pass`  out  1  `done` && `err_count`==0.
- `err_count`  out  8  number of mismatches, saturating at 255.
- `first_fail_reg`  out  3  register index of the first mismatch.
- `first_fail_pat`  out  8  pattern index of the first mismatch.

## Operation

- Pattern list, with index p = 0..P-1 and P = NUM_STEP+2:
  - p=0 is 16'h0000.
  - p=1 is 16'hFFFF.
  - p≥2 is SEED + (p-2)*STEP, truncated to 16 bits and kept in a running accumulator. No multiplier.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE or DONE with `start`=1 -> WRITE.
  - On entry: p=0, index=0.
  - `err_count`, `first_fail_*`, `done` and `pass` clear.
- WRITE, 8 cycles:
  - Outputs: `write`=1, `writenum`=index, `data_in`=pattern(p).
  - index increments each cycle. After index 7 -> READ, with index=0.
- READ, 8 cycles:
  - Outputs: `write`=0, `readnum`=index.
  - At each rising edge, `data_out` is compared with pattern(p).
  - On a mismatch, `err_count` increments and saturates at 255.
  - If `err_count` was 0 before the mismatch, `first_fail_reg`=index and `first_fail_pat`=p are captured.
  - After index 7: if p<P-1 -> WRITE with p+1; else -> DONE.
- DONE: `done`=1 and `pass` is valid. Stays in DONE until `start`.
- `abort`=1 in WRITE or READ -> IDLE at the next edge.
  - `write` drops in the same edge.
  - `done` and `pass` stay 0.
  - `err_count` keeps its partial value.
- `abort` has priority over the index/state advance. `abort` in IDLE or DONE is ignored.
- `start` in WRITE or READ is ignored.
- Outside WRITE: `write`=0, `data_in`=0, `writenum`=0.
- Outside READ: `readnum`=0.

## Timing

- All outputs are registered.
- Reset values: state=IDLE, and every output is 0 (`data_in`, `writenum`, `write`, `readnum`, `busy`, `done`, `pass`, `err_count`, `first_fail_reg`, `first_fail_pat`).
- `reset` asserted mid-run forces the reset values immediately, without waiting for a clock edge.
- Reset does not touch register file contents.
- Sequence from the edge that samples `start` (edge 0):
  - WRITE occupies cycles 1..8.
  - READ occupies cycles 9..16.
  - Each pattern takes 16 cycles.
- `done` rises after edge 16*P: edge 160 for defaults.
- Latency from `start` to `done` is 16*P+1 edges, including the sampling edge.
- Writes commit at the rising edge ending each WRITE cycle. Register r holds pattern(p) from the end of WRITE cycle r onward.
- A read compare happens at the edge ending each READ cycle. `data_out` must settle within that cycle.
- The first read of pattern p follows the last write of pattern p by one edge; no extra gap.
- `busy` is 1 in exactly the cycles where `write` or `readnum` is under BIST control.

## Test plan

- **Golden run.** Behavioural regfile model, defaults, `start` pulsed 1 cycle:
  - Required: `write` high cycles 1..8 with `data_in`=16'h0000.
  - Required: `done`=1 and `pass`=1 after edge 160, `err_count`=0.
  - Required: `data_in` for p=2..9 is 000F, 0C68, 18C1, 251A, 3173, 3DCC, 4A25, 567E.
- **Stuck-at-1 on R3 bit 0.**
  - Required: `err_count`=5 (patterns 0000, 0C68, 251A, 3DCC, 567E).
  - Required: `first_fail_reg`=3, `first_fail_pat`=0, `pass`=0.
- **`data_out` bit 15 forced to 0.**
  - Required: `err_count`=8, all from p=1 (FFFF), `first_fail_reg`=0, `first_fail_pat`=1.
- **Abort.** `abort` pulsed at cycle 40:
  - Required: `busy` and `write` are 0 after that edge, state is IDLE, `done`=0.
  - Required: a following `start` completes a full run 161 edges later with `pass`=1.
- **Reset and start during a run.**
  - `reset` asserted mid-WRITE at cycle 20: all outputs are 0 before the next clock edge.
  - `start` re-pulsed at cycle 50 of a run: ignored, and `done` still rises after edge 160.

Source files
------------

// File: rtl/regfile_bist.sv
// Pattern-sweep self-test for the 8 x 16-bit register file.
// Writes every register with each pattern, then reads back and compares.
module regfile_bist #(
    parameter int          NUM_STEP = 8,
    parameter logic [15:0] SEED     = 16'h000F,
    parameter logic [15:0] STEP     = 16'h0C59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] data_out,
    output logic [15:0] data_in,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [2:0]  readnum,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [2:0]  first_fail_reg,
    output logic [7:0]  first_fail_pat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] P_LAST = 8'(NUM_STEP + 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  p_q, p_d;
    logic [15:0] pat_q, pat_d;
    logic [7:0]  err_q, err_d;
    logic [2:0]  ffr_q, ffr_d;
    logic [7:0]  ffp_q, ffp_d;
    logic [15:0] din_q, din_d;
    logic [2:0]  wnum_q, wnum_d;
    logic        wr_q, wr_d;
    logic [2:0]  rnum_q, rnum_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        p_d     = p_q;
        pat_d   = pat_q;
        err_d   = err_q;
        ffr_d   = ffr_q;
        ffp_d   = ffp_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WRITE;
                    idx_d   = 3'd0;
                    p_d     = 8'd0;
                    pat_d   = 16'h0000;
                    err_d   = 8'd0;
                    ffr_d   = 3'd0;
                    ffp_d   = 8'd0;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_READ;
                end
            end
            default: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (data_out != pat_q) begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        if (err_q == 8'd0) begin
                            ffr_d = idx_q;
                            ffp_d = p_q;
                        end
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (p_q == P_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WRITE;
                            p_d     = p_q + 8'd1;
                            // Running accumulator replaces SEED + k*STEP
                            if (p_q == 8'd0)      pat_d = 16'hFFFF;
                            else if (p_q == 8'd1) pat_d = SEED;
                            else                  pat_d = pat_q + STEP;
                        end
                    end
                end
            end
        endcase
        wr_d   = (state_d == S_WRITE);
        wnum_d = wr_d ? idx_d : 3'd0;
        din_d  = wr_d ? pat_d : 16'h0000;
        rnum_d = (state_d == S_READ) ? idx_d : 3'd0;
        busy_d = (state_d == S_WRITE) || (state_d == S_READ);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 8'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            p_q     <= 8'd0;
            pat_q   <= 16'h0000;
            err_q   <= 8'd0;
            ffr_q   <= 3'd0;
            ffp_q   <= 8'd0;
            din_q   <= 16'h0000;
            wnum_q  <= 3'd0;
            wr_q    <= 1'b0;
            rnum_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
            ffr_q   <= ffr_d;
            ffp_q   <= ffp_d;
            din_q   <= din_d;
            wnum_q  <= wnum_d;
            wr_q    <= wr_d;
            rnum_q  <= rnum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign data_in        = din_q;
    assign writenum       = wnum_q;
    assign write          = wr_q;
    assign readnum        = rnum_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_reg = ffr_q;
    assign first_fail_pat = ffp_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: behavioural register file with injectable
// stuck-at faults, and an expected-result model built from the pattern rules.
module tb_regfile_bist;

    localparam int          NSTEP = 8;
    localparam int          P     = NSTEP + 2;
    localparam logic [15:0] SEED  = 16'h000F;
    localparam logic [15:0] STEP  = 16'h0C59;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;
    logic [2:0]  first_fail_reg;
    logic [7:0]  first_fail_pat;

    logic [15:0] rf [8];
    int          f_on;
    int          f_reg;
    int          f_bit;
    int          f_val;
    int          checks = 0;
    int          errors = 0;

    regfile_bist dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .data_out       (data_out),
        .data_in        (data_in),
        .writenum       (writenum),
        .write          (write),
        .readnum        (readnum),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_reg (first_fail_reg),
        .first_fail_pat (first_fail_pat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write) rf[writenum] <= data_in;
    end

    function automatic logic [15:0] faulty(input logic [15:0] v, input int r);
        logic [15:0] o;
        o = v;
        if (f_on != 0 && (f_reg == 8 || f_reg == r)) o[f_bit] = f_val[0];
        return o;
    endfunction

    always_comb begin
        data_out = faulty(rf[readnum], int'(readnum));
    end

    function automatic logic [15:0] pattern(input int p);
        if (p == 0) return 16'h0000;
        if (p == 1) return 16'hFFFF;
        return 16'(int'(SEED) + (p - 2) * int'(STEP));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_run(output int e, output int fr, output int fp);
        logic [15:0] v;
        e  = 0;
        fr = 0;
        fp = 0;
        for (int p = 0; p < P; p++) begin
            for (int r = 0; r < 8; r++) begin
                v = pattern(p);
                if (faulty(v, r) != v) begin
                    if (e == 0) begin
                        fr = r;
                        fp = p;
                    end
                    if (e < 255) e++;
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_din"}, 32'(data_in), 0);
        chk({tag, "_wnum"}, 32'(writenum), 0);
        chk({tag, "_wr"}, 32'(write), 0);
        chk({tag, "_rnum"}, 32'(readnum), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_ffr"}, 32'(first_fail_reg), 0);
        chk({tag, "_ffp"}, 32'(first_fail_pat), 0);
    endtask

    // Full run from a start pulse; optional restart pulse mid-run.
    task automatic run_full(input string tag, input int restart_cyc);
        int e, fr, fp, p, ph;
        expect_run(e, fr, fp);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 16 * P; cyc++) begin
            p  = (cyc - 1) / 16;
            ph = (cyc - 1) % 16;
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_done_early"}, 32'(done), 0);
            chk({tag, "_wr"}, 32'(write), (ph < 8) ? 1 : 0);
            if (ph < 8) begin
                chk({tag, "_din"}, 32'(data_in), 32'(pattern(p)));
                chk({tag, "_wnum"}, 32'(writenum), ph);
                chk({tag, "_rnum0"}, 32'(readnum), 0);
            end else begin
                chk({tag, "_rnum"}, 32'(readnum), ph - 8);
                chk({tag, "_din0"}, 32'(data_in), 0);
            end
            if (cyc == restart_cyc) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err_count), e);
        chk({tag, "_pass"}, 32'(pass), (e == 0) ? 1 : 0);
        if (e != 0) begin
            chk({tag, "_ffr"}, 32'(first_fail_reg), fr);
            chk({tag, "_ffp"}, 32'(first_fail_pat), fp);
        end
        repeat (3) @(posedge clk);
        #1 chk({tag, "_done_hold"}, 32'(done), 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int e, fr, fp;
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
        f_on  = 0;
        f_reg = 0;
        f_bit = 0;
        f_val = 0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cycles(2);
        check_idle_outputs("rst");
        #2 reset = 1'b0;
        cycles(2);

        run_full("golden", 0);

        f_on = 1; f_reg = 3; f_bit = 0; f_val = 1;
        expect_run(e, fr, fp);
        chk("model_sa1", 32'(e), 5);
        run_full("sa1_r3b0", 0);

        f_on = 1; f_reg = 8; f_bit = 15; f_val = 0;
        expect_run(e, fr, fp);
        chk("model_b15", 32'(e), 8);
        run_full("b15_zero", 0);

        f_on = 0;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(39);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_wr", 32'(write), 0);
        chk("abort_done", 32'(done), 0);
        cycles(5);
        chk("abort_idle", 32'(busy), 0);
        run_full("after_abort", 0);

        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(19);
        reset = 1'b1;
        #1 check_idle_outputs("midrst");
        @(posedge clk);
        #1 reset = 1'b0;
        cycles(2);
        check_idle_outputs("postrst");

        for (int k = 0; k < 4; k++) begin
            f_on  = int'($urandom_range(0, 1));
            f_reg = int'($urandom_range(0, 8));
            f_bit = int'($urandom_range(0, 15));
            f_val = int'($urandom_range(0, 1));
            run_full($sformatf("rand%0d", k), (k == 1) ? 50 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
